// File: rtl/mod_audio_pkg.sv
// Shared audio stream types and defaults.
// Used by the synth driver and the I2S DAC transmitter.
package mod_audio_pkg;

  localparam int SLOT_BITS_DEFAULT = 16;
  localparam int BCLK_HALF_DEFAULT = 16;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/mod_i2s_dac_tx_if.sv
// Stereo sample stream handshake.
// Producer drives sample/valid, consumer drives ready.
interface mod_i2s_dac_tx_if;
  import mod_audio_pkg::*;

  stereo_sample_t i_sample;
  logic           i_valid;
  logic           o_ready;

  modport master (
    output i_sample,
    output i_valid,
    input  o_ready
  );

  modport slave (
    input  i_sample,
    input  i_valid,
    output o_ready
  );

endinterface

// File: rtl/mod_bclk_gen.sv
// I2S bit clock divider and slot bit counter.
// Strobes mark the cycle before each BCLK edge.
module mod_bclk_gen #(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 16
) (
  input  logic i_clk,
  input  logic i_nrst,
  output logic o_bclk,
  output logic o_lrck,
  output logic o_fall_strobe,
  output logic o_rise_strobe,
  output logic o_frame_load
);

  localparam int DW =
    (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);

  localparam logic [DW-1:0] DIV_MAX =
    DW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] BIT_MAX =
    BW'(2 * SLOT_BITS - 1);
  localparam logic [BW-1:0] BIT_SLOT =
    BW'(SLOT_BITS);

  logic [DW-1:0] r_div_q;
  logic [BW-1:0] r_bit_q;
  logic          r_bclk;
  logic          r_lrck;
  logic          w_wrap;
  logic [BW-1:0] w_bit_nxt;

  assign w_wrap        = (r_div_q == DIV_MAX);
  assign o_fall_strobe = w_wrap & r_bclk;
  assign o_rise_strobe = w_wrap & ~r_bclk;
  assign o_frame_load  =
    o_fall_strobe & (r_bit_q == '0);
  assign w_bit_nxt =
    (r_bit_q == BIT_MAX) ? '0 : r_bit_q + 1'b1;

  assign o_bclk = r_bclk;
  assign o_lrck = r_lrck;

  // Half-period divider; toggles BCLK on wrap.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_div_q <= '0;
      r_bclk  <= 1'b0;
    end else if (w_wrap) begin
      r_div_q <= '0;
      r_bclk  <= ~r_bclk;
    end else begin
      r_div_q <= r_div_q + 1'b1;
    end
  end

  // Bit position in frame; LRCK follows on falling BCLK.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_bit_q <= '0;
      r_lrck  <= 1'b0;
    end else if (o_fall_strobe) begin
      r_bit_q <= w_bit_nxt;
      r_lrck  <= (w_bit_nxt >= BIT_SLOT);
    end
  end

endmodule

// File: rtl/mod_i2s_dac_tx.sv
// I2S DAC transmitter, BCLK/LRCK master.
// One-word holding buffer feeding a frame shifter.
module mod_i2s_dac_tx
  import mod_audio_pkg::*;
#(
  parameter int BCLK_HALF = BCLK_HALF_DEFAULT,
  parameter int SLOT_BITS = SLOT_BITS_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  mod_i2s_dac_tx_if.slave  s_if,
  output logic             o_aud_bclk,
  output logic             o_aud_daclrck,
  output logic             o_aud_dacdat,
  output logic             o_underrun
);

  stereo_sample_t r_hold_q;
  stereo_sample_t r_last_q;
  logic [31:0]    r_shift_q;
  logic           r_full_q;
  logic           r_underrun;

  logic w_fall;
  logic w_load;
  logic w_accept;
  logic w_unused_rise;

  mod_bclk_gen #(
    .BCLK_HALF (BCLK_HALF),
    .SLOT_BITS (SLOT_BITS)
  ) u_bclk_gen (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .o_bclk        (o_aud_bclk),
    .o_lrck        (o_aud_daclrck),
    .o_fall_strobe (w_fall),
    .o_rise_strobe (w_unused_rise),
    .o_frame_load  (w_load)
  );

  assign w_accept     = s_if.i_valid & ~r_full_q;
  assign s_if.o_ready = ~r_full_q;
  assign o_aud_dacdat = r_shift_q[31];
  assign o_underrun   = r_underrun;

  // Holding register; a load in the accept cycle
  // still sees the old contents.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_hold_q <= '0;
      r_full_q <= 1'b0;
    end else if (w_accept) begin
      r_hold_q <= s_if.i_sample;
      r_full_q <= 1'b1;
    end else if (w_load) begin
      r_full_q <= 1'b0;
    end
  end

  // Frame shifter; repeats last frame when starved.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_shift_q <= '0;
      r_last_q  <= '0;
    end else if (w_load) begin
      if (r_full_q) begin
        r_shift_q <= r_hold_q;
        r_last_q  <= r_hold_q;
      end else begin
        r_shift_q <= r_last_q;
      end
    end else if (w_fall) begin
      r_shift_q <= {r_shift_q[30:0], 1'b0};
    end
  end

  // One-cycle underrun flag on a starved frame load.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load & ~r_full_q;
    end
  end

endmodule

// File: tb/tb_mod_i2s_dac_tx.sv
// Scoreboard bench for the I2S DAC transmitter.
// BCLK_HALF=2, SLOT_BITS=16: frame loads at edge 4+128k.
module tb_mod_i2s_dac_tx;
  import mod_audio_pkg::*;

  typedef struct packed {
    logic [31:0] w;
    logic        ur;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk, lrck, dat, ur;
  int   checks = 0;
  int   fails = 0;
  int   ecnt = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  mod_i2s_dac_tx_if s_if();

  mod_i2s_dac_tx #(
    .BCLK_HALF (2),
    .SLOT_BITS (16)
  ) dut (
    .i_clk         (clk),
    .i_nrst        (rst_n),
    .s_if          (s_if),
    .o_aud_bclk    (bclk),
    .o_aud_daclrck (lrck),
    .o_aud_dacdat  (dat),
    .o_underrun    (ur)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [31:0] w,
                              input logic u);
    exp_t e;
    e.w  = w;
    e.ur = u;
    q.push_back(e);
  endtask

  // Monitor: collect bits at rising BCLK, close a frame
  // when LRCK returns low (last right-slot bit).
  logic [31:0] m_acc;
  logic        m_pb, m_pl;
  int          m_ur;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      m_acc = '0;
      m_pb  = 1'b0;
      m_pl  = 1'b0;
      m_ur  = 0;
    end else begin
      if (ur) m_ur++;
      if (bclk && !m_pb) begin
        m_acc = {m_acc[30:0], dat};
        if (!lrck && m_pl) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL frame_extra actual=%0h required=none",
                     m_acc);
          end else begin
            e = q.pop_front();
            check("frame_data", m_acc, e.w);
            check("frame_underrun", 32'(m_ur),
                  {31'b0, e.ur});
          end
          m_ur = 0;
        end
        m_pl = lrck;
      end
      m_pb = bclk;
    end
  end

  // Advance to the negedge just before posedge number e.
  task automatic wait_to(input int e);
    int n = 0;
    while (ecnt != e - 1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      fails++;
      $display("FAIL wait_to actual=%0d required=%0d",
               ecnt, e - 1);
    end
  endtask

  task automatic push(input logic [31:0] w,
                      output int acc_edge);
    logic r;
    bit   ok = 0;
    s_if.i_valid  = 1'b1;
    s_if.i_sample = w;
    for (int i = 0; i < 2000; i++) begin
      r = s_if.o_ready;
      @(negedge clk);
      if (r) begin
        ok = 1;
        break;
      end
    end
    s_if.i_valid = 1'b0;
    acc_edge = ecnt;
    check("push_accepted", 32'(ok), 32'd1);
    check("ready_drop", 32'(s_if.o_ready), 32'd0);
  endtask

  // BCLK/LRCK/underrun phase after a reset release.
  task automatic timing_checks();
    int   tc[10] = '{1, 2, 3, 4, 5, 6, 63, 64, 127, 128};
    logic tb[10] = '{0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
    logic tl[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    logic tu[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      wait_to(tc[i] + 1);
      check("t_bclk", 32'(bclk), 32'(tb[i]));
      check("t_lrck", 32'(lrck), 32'(tl[i]));
      check("t_underrun", 32'(ur), 32'(tu[i]));
      check("t_dacdat", 32'(dat), 32'd0);
    end
  endtask

  initial begin
    int e;
    s_if.i_valid  = 1'b0;
    s_if.i_sample = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(s_if.o_ready), 32'd1);
    check("rst_bclk", 32'(bclk), 32'd0);
    rst_n = 1'b1;

    expect_frame(32'h0, 1'b1);
    expect_frame(32'h0, 1'b1);
    timing_checks();

    expect_frame(32'hA5F0_1234, 1'b0);
    wait_to(201);
    push(32'hA5F0_1234, e);

    expect_frame(32'h0001_8000, 1'b0);
    wait_to(301);
    push(32'h0001_8000, e);
    expect_frame(32'h7FFF_FFFF, 1'b0);
    wait_to(431);
    push(32'h7FFF_FFFF, e);
    wait_to(516);
    check("ready_held", 32'(s_if.o_ready), 32'd0);
    wait_to(517);
    check("ready_back", 32'(s_if.o_ready), 32'd1);

    expect_frame(32'h1111_2222, 1'b0);
    expect_frame(32'h3333_4444, 1'b0);
    expect_frame(32'h3333_4444, 1'b1);
    wait_to(541);
    push(32'h1111_2222, e);
    push(32'h3333_4444, e);
    check("holdoff_edge", 32'(e), 32'd645);

    expect_frame(32'h3333_4444, 1'b1);
    expect_frame(32'h5A5A_C3C3, 1'b0);
    wait_to(1028);
    push(32'h5A5A_C3C3, e);
    check("samecyc_edge", 32'(e), 32'd1028);

    wait_to(1301);
    push(32'hDEAD_BEEF, e);
    wait_to(1362);
    check("pre_rst_lrck", 32'(lrck), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bclk", 32'(bclk), 32'd0);
    check("mid_rst_lrck", 32'(lrck), 32'd0);
    check("mid_rst_dat", 32'(dat), 32'd0);
    check("mid_rst_ready", 32'(s_if.o_ready), 32'd1);
    check("mid_rst_ur", 32'(ur), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    expect_frame(32'h0, 1'b1);
    expect_frame(32'h0, 1'b1);
    timing_checks();
    expect_frame(32'h0F0F_F0F0, 1'b0);
    expect_frame(32'h0F0F_F0F0, 1'b1);
    wait_to(151);
    push(32'h0F0F_F0F0, e);

    for (int n = 0; n < 2000 && q.size() > 0; n++)
      @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
